// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with a 4-entry FIFO
// Register window: BASE+0 TXDATA, BASE+1 STATUS, BASE+2 DIVISOR.
module mmio_uart_tx #(
    parameter logic [15:0] BASE      = 16'hFF00,
    parameter logic [15:0] DIV_RESET = 16'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] raddr,
    input  logic        re,
    output logic [15:0] rdata,
    output logic        rhit,
    input  logic [15:0] waddr,
    input  logic [15:0] wdata,
    input  logic        we,
    output logic        tx
);

    localparam logic [15:0] ADDR_TX  = BASE;
    localparam logic [15:0] ADDR_ST  = BASE + 16'd1;
    localparam logic [15:0] ADDR_DIV = BASE + 16'd2;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state_q, state_d;
    logic [7:0]  fifo_q [4];
    logic [7:0]  fifo_d [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic        ovf_q, ovf_d;
    logic [15:0] div_q, div_d;
    logic [15:0] bdiv_q, bdiv_d;
    logic [15:0] cyc_q, cyc_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic [15:0] rdata_q, rdata_d;
    logic        rhit_q, rhit_d;

    logic        wr_tx, wr_st, wr_div;
    logic        full, empty, pop, push, ovf_set, bit_end;
    logic [15:0] div_eff;
    logic [15:0] status;

    assign wr_tx   = we && (waddr == ADDR_TX);
    assign wr_st   = we && (waddr == ADDR_ST);
    assign wr_div  = we && (waddr == ADDR_DIV);
    assign full    = (count_q == 3'd4);
    assign empty   = (count_q == 3'd0);
    assign pop     = (state_q == IDLE) && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign push    = wr_tx && (!full || pop);
    assign ovf_set = wr_tx && full && !pop;
    assign bit_end = (cyc_q == bdiv_q - 16'd1);
    assign div_eff = (div_q == 16'd0) ? 16'd1 : div_q;
    assign status  = {9'd0, count_q, ovf_q, empty, full, (state_q != IDLE)};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            for (int i = 0; i < 4; i++) fifo_q[i] <= 8'd0;
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
            ovf_q    <= 1'b0;
            div_q    <= DIV_RESET;
            bdiv_q   <= 16'd1;
            cyc_q    <= 16'd0;
            idx_q    <= 3'd0;
            shift_q  <= 8'd0;
            tx_q     <= 1'b1;
            rdata_q  <= 16'd0;
            rhit_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            div_q    <= div_d;
            bdiv_q   <= bdiv_d;
            cyc_q    <= cyc_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            rdata_q  <= rdata_d;
            rhit_q   <= rhit_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (!empty) state_d = START;
            START:   if (bit_end) state_d = DATA;
            DATA:    if (bit_end && (idx_q == 3'd7)) state_d = STOP;
            STOP:    if (bit_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            fifo_d[wr_ptr_q] = wdata[7:0];
            wr_ptr_d         = wr_ptr_q + 2'd1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
        if (push && !pop) count_d = count_q + 3'd1;
        else if (pop && !push) count_d = count_q - 3'd1;

        // A same-cycle overflow beats the STATUS-write clear.
        ovf_d = ovf_q;
        if (ovf_set) ovf_d = 1'b1;
        else if (wr_st) ovf_d = 1'b0;

        div_d   = wr_div ? wdata : div_q;
        shift_d = pop ? fifo_q[rd_ptr_q] : shift_q;
        bdiv_d  = pop ? div_eff : bdiv_q;

        cyc_d = bit_end ? 16'd0 : cyc_q + 16'd1;
        idx_d = idx_q;
        if (state_q == IDLE) begin
            cyc_d = 16'd0;
            idx_d = 3'd0;
        end else if ((state_q == DATA) && bit_end) begin
            idx_d = idx_q + 3'd1;
        end

        // tx is computed from the next state so the flop lines up with state_q.
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[idx_d];
            default: tx_d = 1'b1;
        endcase

        rhit_d  = 1'b0;
        rdata_d = 16'd0;
        if (re) begin
            if (raddr == ADDR_TX) begin
                rhit_d = 1'b1;
            end else if (raddr == ADDR_ST) begin
                rhit_d  = 1'b1;
                rdata_d = status;
            end else if (raddr == ADDR_DIV) begin
                rhit_d  = 1'b1;
                rdata_d = div_q;
            end
        end
    end

    assign tx    = tx_q;
    assign rdata = rdata_q;
    assign rhit  = rhit_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - scoreboard bench for mmio_uart_tx
module tb_mmio_uart_tx;

    localparam logic [15:0] BASE = 16'hFF00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] raddr = 16'd0;
    logic        re = 1'b0;
    logic [15:0] rdata;
    logic        rhit;
    logic [15:0] waddr = 16'd0;
    logic [15:0] wdata = 16'd0;
    logic        we = 1'b0;
    logic        tx;

    mmio_uart_tx #(.BASE(BASE), .DIV_RESET(16'd4)) dut (
        .clk(clk), .rst(rst), .raddr(raddr), .re(re), .rdata(rdata), .rhit(rhit),
        .waddr(waddr), .wdata(wdata), .we(we), .tx(tx)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] sb [$];
    int         starts [$];
    int         cur_d = 4;
    int         cyc = 0;
    logic       mon_active = 1'b0;
    int         mon_j = 0;
    int         mon_d = 1;
    int         mon_err = 0;
    logic [7:0] mon_rx = 8'd0;
    logic [7:0] mon_exp = 8'd0;
    logic [9:0] mon_pat = 10'd0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic accept);
        we = 1'b1; waddr = a; wdata = d;
        if (accept) sb.push_back(d[7:0]);
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] a, input logic [15:0] exp, input logic exp_hit);
        re = 1'b1; raddr = a;
        @(posedge clk); #1;
        re = 1'b0;
        check({tag, "_rdata"}, rdata, exp);
        check({tag, "_rhit"}, rhit, exp_hit);
    endtask

    task automatic drain(input string tag);
        int quiet = 0;
        int t = 0;
        while (quiet < 4 && t < 3000) begin
            @(posedge clk); #1;
            t++;
            if (sb.size() == 0 && !mon_active) quiet++;
            else quiet = 0;
        end
        check({tag, "_drain"}, quiet >= 4, 1);
    endtask

    // Line monitor: decodes each frame sample-by-sample against the expected byte.
    initial begin
        int k;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                mon_active = 1'b0;
            end else if (!mon_active) begin
                if (tx === 1'b0) begin
                    starts.push_back(cyc);
                    mon_d = cur_d; mon_j = 1; mon_err = 0; mon_rx = 8'd0;
                    if (sb.size() == 0) begin
                        check("unexpected_frame", 1, 0);
                        mon_exp = 8'h00;
                    end else begin
                        mon_exp = sb.pop_front();
                    end
                    mon_pat = {1'b1, mon_exp, 1'b0};
                    mon_active = 1'b1;
                end
            end else begin
                k = mon_j / mon_d;
                if (tx !== mon_pat[k]) mon_err++;
                if (k >= 1 && k <= 8 && (mon_j % mon_d) == mon_d / 2) mon_rx[k-1] = tx;
                mon_j++;
                if (mon_j == 10 * mon_d) begin
                    check("frame_shape", mon_err, 0);
                    check("frame_byte", mon_rx, mon_exp);
                    mon_active = 1'b0;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int nstart;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_tx", tx, 1);
        check("reset_rhit", rhit, 0);
        rd_chk("reset_status", BASE + 16'd1, 16'h0004, 1'b1);
        rd_chk("reset_div", BASE + 16'd2, 16'h0004, 1'b1);
        rd_chk("txdata_read", BASE, 16'h0000, 1'b1);

        // Single frame; first read reports the pre-pop state, second the busy frame.
        base = starts.size();
        wr(BASE, 16'h0055, 1'b1);
        rd_chk("status_prepop", BASE + 16'd1, 16'h0010, 1'b1);
        rd_chk("status_busy", BASE + 16'd1, 16'h0005, 1'b1);
        drain("f55");
        check("f55_count", starts.size() - base, 1);
        rd_chk("status_idle", BASE + 16'd1, 16'h0004, 1'b1);

        // Six back-to-back writes: one pops, four queue, the last overflows.
        base = starts.size();
        for (int i = 0; i < 6; i++) wr(BASE, 16'h00A0 + 16'(i), i < 5);
        rd_chk("status_full", BASE + 16'd1, 16'h004B, 1'b1);
        drain("burst");
        check("burst_frames", starts.size() - base, 5);
        for (int i = 1; i < 5 && base + i < starts.size(); i++)
            check("burst_gap", starts[base+i] - starts[base+i-1], 41);
        rd_chk("status_ovf", BASE + 16'd1, 16'h000C, 1'b1);
        wr(BASE + 16'd1, 16'h0000, 1'b0);
        rd_chk("status_clr", BASE + 16'd1, 16'h0004, 1'b1);

        // DIVISOR write mid-frame leaves the current frame at D=4.
        wr(BASE, 16'h0055, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        wr(BASE + 16'd2, 16'h0002, 1'b0);
        cur_d = 2;
        drain("middiv");
        rd_chk("div2", BASE + 16'd2, 16'h0002, 1'b1);
        wr(BASE, 16'h003C, 1'b1);
        drain("d2");

        // DIVISOR=0 runs at one clock per bit.
        wr(BASE + 16'd2, 16'h0000, 1'b0);
        cur_d = 1;
        rd_chk("div0", BASE + 16'd2, 16'h0000, 1'b1);
        base = starts.size();
        wr(BASE, 16'h00FF, 1'b1);
        wr(BASE, 16'h0000, 1'b1);
        drain("d1");
        check("d1_frames", starts.size() - base, 2);
        if (starts.size() >= base + 2) check("d1_gap", starts[base+1] - starts[base], 11);

        // Reset during DATA bit 3 with two bytes queued.
        wr(BASE + 16'd2, 16'h0004, 1'b0);
        cur_d = 4;
        for (int i = 0; i < 3; i++) wr(BASE, 16'h00B0 + 16'(i), 1'b1);
        begin
            int t = 0;
            while (!(mon_active && mon_j >= 17) && t < 200) begin
                @(posedge clk); #1;
                t++;
            end
            check("reach_bit3", t < 200, 1);
        end
        rst = 1'b1;
        sb.delete();
        wr(BASE + 16'd2, 16'h0009, 1'b0);
        check("rst_tx", tx, 1);
        wr(BASE, 16'h00EE, 1'b0);
        rst = 1'b0;
        nstart = starts.size();
        rd_chk("rst_status", BASE + 16'd1, 16'h0004, 1'b1);
        rd_chk("rst_div", BASE + 16'd2, 16'h0004, 1'b1);
        repeat (150) @(posedge clk);
        #1;
        check("rst_no_frames", starts.size() - nstart, 0);

        // Addresses outside the window.
        nstart = starts.size();
        wr(BASE + 16'd3, 16'hFFFF, 1'b0);
        wr(16'h0000, 16'h1234, 1'b0);
        rd_chk("oob_base3", BASE + 16'd3, 16'h0000, 1'b0);
        rd_chk("oob_zero", 16'h0000, 16'h0000, 1'b0);
        rd_chk("oob_status", BASE + 16'd1, 16'h0004, 1'b1);
        rd_chk("oob_div", BASE + 16'd2, 16'h0004, 1'b1);
        repeat (60) @(posedge clk);
        #1;
        check("oob_no_frames", starts.size() - nstart, 0);
        check("tx_idle_end", tx, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
